// File: rtl/pot_spi_master_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// pot_spi_master_if : request/data and SPI pin bundle for pot_spi_master
// Optional ports under `POT_SPI_READBACK_EN. Revision 1.0
//------------------------------------------------------------------------------
interface pot_spi_master_if;
  logic [15:0] dat_spi_in;
  logic        send_data_spi;
  logic        send_ok_strobe;
  logic        pot_busy;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
`ifdef POT_SPI_READBACK_EN
  logic        spi_miso;
  logic [15:0] rd_data;

  modport master (
    input  dat_spi_in, send_data_spi, spi_miso,
    output send_ok_strobe, pot_busy, spi_cs_n, spi_sclk, spi_mosi, rd_data
  );
  modport slave (
    output dat_spi_in, send_data_spi, spi_miso,
    input  send_ok_strobe, pot_busy, spi_cs_n, spi_sclk, spi_mosi, rd_data
  );
`else
  modport master (
    input  dat_spi_in, send_data_spi,
    output send_ok_strobe, pot_busy, spi_cs_n, spi_sclk, spi_mosi
  );
  modport slave (
    output dat_spi_in, send_data_spi,
    input  send_ok_strobe, pot_busy, spi_cs_n, spi_sclk, spi_mosi
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pot_spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// pot_spi_master : SPI mode-0 master shifting a 16-bit potentiometer word MSB-first
// Define POT_SPI_READBACK_EN to add MISO capture into rd_data. Revision 1.0
//------------------------------------------------------------------------------
module pot_spi_master #(
  parameter int CLK_DIV  = 25,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int GAP      = 8
) (
  input wire               clk,
  input wire               rst,
  pot_spi_master_if.master bus
);

  localparam int c_SHIFT_CYC = 32 * CLK_DIV;
  localparam int c_MAX_A     = (c_SHIFT_CYC > CS_SETUP) ? c_SHIFT_CYC : CS_SETUP;
  localparam int c_MAX_B     = (CS_HOLD > GAP) ? CS_HOLD : GAP;
  localparam int c_MAX       = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_CNT_W     = $clog2(c_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP_W = 3'd4,
    DONE  = 3'd5,
    REARM = 3'd6
  } state_t;

  state_t             r_state, w_state_nx;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [4:0]         r_half, w_half_nx;
  logic [15:0]        r_shift, w_shift_nx;

  logic w_cs_n, w_sclk, w_mosi, w_strobe, w_busy;
  logic r_cs_n, r_sclk, r_mosi, r_strobe, r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_half   <= '0;
      r_shift  <= '0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_half   <= w_half_nx;
      r_shift  <= w_shift_nx;
      r_cs_n   <= w_cs_n;
      r_sclk   <= w_sclk;
      r_mosi   <= w_mosi;
      r_strobe <= w_strobe;
      r_busy   <= w_busy;
    end
  end

  // Outputs are decoded from the current state and registered, so every pin
  // lags the state register by one cycle; relative timing is preserved.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_half_nx  = r_half;
    w_shift_nx = r_shift;
    w_cs_n     = 1'b1;
    w_sclk     = 1'b0;
    w_mosi     = 1'b0;
    w_strobe   = 1'b0;
    w_busy     = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (bus.send_data_spi) begin
          w_shift_nx = bus.dat_spi_in;
          w_cnt_nx   = '0;
          w_half_nx  = '0;
          w_state_nx = SETUP;
        end
      end
      SETUP: begin
        w_cs_n = 1'b0;
        w_mosi = r_shift[15];
        if (r_cnt == c_SETUP_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = SHIFT;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      SHIFT: begin
        w_cs_n = 1'b0;
        w_sclk = r_half[0];
        w_mosi = r_shift[15];
        if (r_cnt == c_DIV_LAST) begin
          w_cnt_nx = '0;
          // End of a high half-period is an SCLK fall: present the next bit.
          if (r_half[0]) begin
            w_shift_nx = {r_shift[14:0], 1'b0};
          end
          if (r_half == 5'd31) begin
            w_state_nx = HOLD;
          end else begin
            w_half_nx = r_half + 5'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        w_cs_n = 1'b0;
        if (r_cnt == c_HOLD_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = GAP_W;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      GAP_W: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nx   = '0;
          w_state_nx = DONE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_strobe   = 1'b1;
        w_state_nx = REARM;
      end
      REARM: begin
        // Wait out the upstream request so its late clear cannot re-trigger.
        if (!bus.send_data_spi) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign bus.send_ok_strobe = r_strobe;
  assign bus.pot_busy       = r_busy;
  assign bus.spi_cs_n       = r_cs_n;
  assign bus.spi_sclk       = r_sclk;
  assign bus.spi_mosi       = r_mosi;

`ifdef POT_SPI_READBACK_EN
  logic [15:0] r_miso_sh;
  logic [15:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miso_sh <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_sclk && !r_sclk) begin
        r_miso_sh <= {r_miso_sh[14:0], bus.spi_miso};
      end
      if (w_strobe) begin
        r_rd_data <= r_miso_sh;
      end
    end
  end

  assign bus.rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pot_spi_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pot_spi_master : scoreboard bench for pot_spi_master (CLK_DIV=2 build)
//------------------------------------------------------------------------------
module tb_pot_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int GAP      = 8;
  localparam int c_LAT    = 1 + CS_SETUP + 32 * CLK_DIV + CS_HOLD + GAP;
  localparam int c_CS_LOW = CS_SETUP + 32 * CLK_DIV + CS_HOLD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pot_spi_master_if ifc ();

  pot_spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .GAP     (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q_exp[$];
  logic [15:0] q_got[$];
  int          q_cslen[$];

  // SPI slave-side monitor
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_mosi = 1'b0;
  logic [15:0] cap       = '0;
  int bits = 0, cs_len = 0, strobe_cnt = 0, cs_falls = 0;
  int cs_rise_cyc = 0, last_gap = 0, pin_viol = 0;
`ifdef POT_SPI_READBACK_EN
  logic [15:0] miso_word = 16'h0000;
  int          miso_idx = 0;
  logic [15:0] rd_prev = '0, rd_before = '0, rd_at_strobe = '0;
`endif

  always @(negedge clk) begin
    if (prev_cs && !ifc.spi_cs_n) begin
      cs_falls++;
      bits     = 0;
      cs_len   = 0;
      last_gap = cyc - cs_rise_cyc;
`ifdef POT_SPI_READBACK_EN
      miso_idx     = 15;
      ifc.spi_miso = miso_word[15];
`endif
    end
`ifdef POT_SPI_READBACK_EN
    else if (prev_sclk && !ifc.spi_sclk && !ifc.spi_cs_n && miso_idx > 0) begin
      miso_idx--;
      ifc.spi_miso = miso_word[miso_idx];
    end
    if (ifc.send_ok_strobe) begin
      rd_at_strobe = ifc.rd_data;
      rd_before    = rd_prev;
    end
    rd_prev = ifc.rd_data;
`endif
    if (!ifc.spi_cs_n) cs_len++;
    if (!prev_sclk && ifc.spi_sclk) begin
      cap = {cap[14:0], ifc.spi_mosi};
      bits++;
    end
    if (prev_sclk && ifc.spi_sclk && (ifc.spi_mosi !== prev_mosi)) pin_viol++;
    if (ifc.spi_cs_n && ifc.spi_sclk) pin_viol++;
    if (!prev_cs && ifc.spi_cs_n) begin
      cs_rise_cyc = cyc;
      if (bits == 16) begin
        q_got.push_back(cap);
        q_cslen.push_back(cs_len);
      end
    end
    if (ifc.send_ok_strobe) strobe_cnt++;
    prev_cs   = ifc.spi_cs_n;
    prev_sclk = ifc.spi_sclk;
    prev_mosi = ifc.spi_mosi;
  end

  // Upstream model: request held until strobe, cleared one cycle later (+hold_after)
  task automatic drive_frame(input logic [15:0] word, input int hold_after,
                             output int lat, output bit tmo);
    int t0;
    @(negedge clk);
    ifc.dat_spi_in    = word;
    ifc.send_data_spi = 1'b1;
    q_exp.push_back(word);
    t0  = cyc;
    tmo = 1'b1;
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.send_ok_strobe) begin
        tmo = 1'b0;
        lat = cyc - t0 - 1;
        break;
      end
    end
    repeat (1 + hold_after) @(negedge clk);
    ifc.send_data_spi = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ifc.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got=%b exp=1", ifc.spi_cs_n); end
    n_checks++; if (ifc.spi_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk got=%b exp=0", ifc.spi_sclk); end
    n_checks++; if (ifc.spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", ifc.spi_mosi); end
    n_checks++; if (ifc.send_ok_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got=%b exp=0", ifc.send_ok_strobe); end
    n_checks++; if (ifc.pot_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", ifc.pot_busy); end
`ifdef POT_SPI_READBACK_EN
    n_checks++; if (ifc.rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", ifc.rd_data); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int lat, s0, f0, cl;
    bit tmo;
    logic [15:0] e, g;
    s0 = strobe_cnt; f0 = cs_falls;
    drive_frame(16'hA5C3, 0, lat, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL frame_timeout got=%b exp=0", tmo); end
    n_checks++; if (lat != c_LAT) begin n_fail++; $display("FAIL frame_latency got=%0d exp=%0d", lat, c_LAT); end
    busy_seen_check();
    repeat (40) @(negedge clk);
    #1;
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL frame_strobes got=%0d exp=1", strobe_cnt - s0); end
    n_checks++; if (cs_falls - f0 != 1) begin n_fail++; $display("FAIL frame_cs_falls got=%0d exp=1", cs_falls - f0); end
    n_checks++; if (ifc.pot_busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_idle got=%b exp=0", ifc.pot_busy); end
    e = q_exp.pop_front();
    n_checks++;
    if (q_got.size() == 0) begin
      n_fail++; $display("FAIL frame_word got=none exp=%h", e);
    end else begin
      g = q_got.pop_front(); cl = q_cslen.pop_front();
      if (g !== e) begin n_fail++; $display("FAIL frame_word got=%h exp=%h", g, e); end
      n_checks++; if (cl != c_CS_LOW) begin n_fail++; $display("FAIL frame_cs_low got=%0d exp=%0d", cl, c_CS_LOW); end
    end
  endtask

  // Busy must be high while the frame is still in its REARM/post-strobe cycle
  task automatic busy_seen_check;
    n_checks++; if (ifc.pot_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame got=%b exp=1", ifc.pot_busy); end
  endtask

  task automatic test_back_to_back;
    int lat, s0, f0;
    bit tmo;
    logic [15:0] e, g;
    s0 = strobe_cnt; f0 = cs_falls;
    drive_frame(16'h5A3C, 10, lat, tmo);
    #1;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout1 got=%b exp=0", tmo); end
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL b2b_held_strobes got=%0d exp=1", strobe_cnt - s0); end
    n_checks++; if (cs_falls - f0 != 1) begin n_fail++; $display("FAIL b2b_held_frames got=%0d exp=1", cs_falls - f0); end
    drive_frame(16'h0F0F, 0, lat, tmo);
    #1;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout2 got=%b exp=0", tmo); end
    n_checks++; if (last_gap < GAP) begin n_fail++; $display("FAIL b2b_cs_gap got=%0d exp>=%0d", last_gap, GAP); end
    for (int k = 0; k < 2; k++) begin
      e = q_exp.pop_front();
      n_checks++;
      if (q_got.size() == 0) begin
        n_fail++; $display("FAIL b2b_word got=none exp=%h", e);
      end else begin
        g = q_got.pop_front(); void'(q_cslen.pop_front());
        if (g !== e) begin n_fail++; $display("FAIL b2b_word got=%h exp=%h", g, e); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int s0, f0;
    bit hit, tmo;
    logic [15:0] e, g;
    s0 = strobe_cnt; f0 = cs_falls; hit = 1'b0; tmo = 1'b1;
    @(negedge clk);
    ifc.dat_spi_in    = 16'hA5C3;
    ifc.send_data_spi = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (cs_falls > f0 && bits == 9) begin hit = 1'b1; break; end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL abort_reach_bit7 got=%b exp=1", hit); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ifc.spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL abort_cs_n got=%b exp=1", ifc.spi_cs_n); end
    n_checks++; if (ifc.spi_sclk !== 1'b0) begin n_fail++; $display("FAIL abort_sclk got=%b exp=0", ifc.spi_sclk); end
    n_checks++; if (ifc.pot_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", ifc.pot_busy); end
    rst = 1'b0;
    q_exp.push_back(16'hA5C3);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.send_ok_strobe) begin tmo = 1'b0; break; end
    end
    @(negedge clk);
    ifc.send_data_spi = 1'b0;
    #1;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL abort_refire_timeout got=%b exp=0", tmo); end
    n_checks++; if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL abort_strobes got=%0d exp=1", strobe_cnt - s0); end
    e = q_exp.pop_front();
    n_checks++;
    if (q_got.size() == 0) begin
      n_fail++; $display("FAIL abort_refire_word got=none exp=%h", e);
    end else begin
      g = q_got.pop_front(); void'(q_cslen.pop_front());
      if (g !== e) begin n_fail++; $display("FAIL abort_refire_word got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_data_change;
    int f0;
    bit tmo;
    logic [15:0] e, g;
    f0 = cs_falls; tmo = 1'b1;
`ifdef POT_SPI_READBACK_EN
    miso_word = 16'h8001;
`endif
    @(negedge clk);
    ifc.dat_spi_in    = 16'h00FF;
    ifc.send_data_spi = 1'b1;
    q_exp.push_back(16'h00FF);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (cs_falls > f0 && bits >= 4) break;
    end
    ifc.dat_spi_in = 16'hFFFF;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.send_ok_strobe) begin tmo = 1'b0; break; end
    end
    @(negedge clk);
    ifc.send_data_spi = 1'b0;
    #1;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL datachg_timeout got=%b exp=0", tmo); end
    e = q_exp.pop_front();
    n_checks++;
    if (q_got.size() == 0) begin
      n_fail++; $display("FAIL datachg_word got=none exp=%h", e);
    end else begin
      g = q_got.pop_front(); void'(q_cslen.pop_front());
      if (g !== e) begin n_fail++; $display("FAIL datachg_word got=%h exp=%h", g, e); end
    end
    repeat (4) @(negedge clk);
  endtask

`ifdef POT_SPI_READBACK_EN
  task automatic test_readback;
    int lat;
    bit tmo;
    logic [15:0] e, g;
    miso_word = 16'h3C5A;
    drive_frame(16'h1111, 0, lat, tmo);
    #1;
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rb_timeout got=%b exp=0", tmo); end
    n_checks++; if (rd_at_strobe !== 16'h3C5A) begin n_fail++; $display("FAIL rb_at_strobe got=%h exp=3c5a", rd_at_strobe); end
    n_checks++; if (rd_before !== 16'h8001) begin n_fail++; $display("FAIL rb_before_strobe got=%h exp=8001", rd_before); end
    e = q_exp.pop_front();
    n_checks++;
    if (q_got.size() == 0) begin
      n_fail++; $display("FAIL rb_word got=none exp=%h", e);
    end else begin
      g = q_got.pop_front(); void'(q_cslen.pop_front());
      if (g !== e) begin n_fail++; $display("FAIL rb_word got=%h exp=%h", g, e); end
    end
  endtask
`endif

  task automatic test_pin_rules;
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (pin_viol != 0) begin n_fail++; $display("FAIL pin_rules got=%0d exp=0", pin_viol); end
    n_checks++; if (q_exp.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", q_exp.size()); end
  endtask

  initial begin
    ifc.dat_spi_in    = 16'h0000;
    ifc.send_data_spi = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_change();
`ifdef POT_SPI_READBACK_EN
    test_readback();
`endif
    test_pin_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pot_spi_master.md
Name: pot_spi_master

Overview:
SPI master for the digital potentiometer, directly downstream of the selector/register stage. It takes the 16-bit word and the level request from that stage, and shifts the word out MSB-first in SPI mode 0. It reports busy for the status readback, then returns a one-cycle completion strobe that clears the upstream request.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (min 1)
CS_SETUP, 4, clk cycles from spi_cs_n fall to first SCLK rise edge window
CS_HOLD, 4, clk cycles from last SCLK fall to spi_cs_n rise
GAP, 8, minimum clk cycles spi_cs_n stays high before next frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
dat_spi_in  input  16  potentiometer word, sampled at frame accept
send_data_spi  input  1  level request; held high by upstream until send_ok_strobe
send_ok_strobe  output  1  one-cycle pulse at frame completion
pot_busy  output  1  high whenever state != IDLE
spi_cs_n  output  1  chip select, active-low
spi_sclk  output  1  serial clock, idle low
spi_mosi  output  1  serial data out

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; spi_cs_n=1, spi_sclk=0, spi_mosi=0, send_ok_strobe=0, pot_busy=0; counters and shift register cleared. Reset mid-frame aborts immediately with no strobe; the upstream request stays pending and is served after reset.
- All outputs are registered.
- States: IDLE, SETUP, SHIFT, HOLD, GAP_W, DONE, REARM.
- IDLE: when send_data_spi=1, latch dat_spi_in into a 16-bit shift register. Next cycle: spi_cs_n=0, spi_mosi=bit15, pot_busy=1, state=SETUP.
- SETUP: lasts CS_SETUP cycles, then SHIFT.
- SHIFT: 16 bits. Each bit is CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high. SHIFT lasts 32*CLK_DIV cycles total.
  - spi_mosi changes only while sclk is low: on entry and on each sclk fall. It is stable across each rise.
  - Bit order: 15 down to 0.
  - After the 16th fall, spi_mosi=0 and state=HOLD.
- HOLD: CS_HOLD cycles with spi_cs_n low and sclk low. Then spi_cs_n=1 and state=GAP_W.
- GAP_W: GAP cycles with spi_cs_n high, then DONE.
- DONE: send_ok_strobe=1 for exactly one cycle, then REARM.
- REARM: remain until send_data_spi=0, then IDLE. pot_busy drops on entry to IDLE. This prevents re-trigger from the one-cycle lag in upstream request clear. A request still high in REARM is never treated as a new frame.
- dat_spi_in changes after accept have no effect on the current frame.
- send_data_spi dropping mid-frame has no effect; the frame completes and strobes.
- Counters must hold at least max(32*CLK_DIV, CS_SETUP, CS_HOLD, GAP). Width is derived with $clog2.
- Frame length from accept edge to strobe: 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + GAP cycles.

Optional Feature:
POT_SPI_READBACK_EN:
- Defined: adds ports spi_miso (input, 1) and rd_data (output, 16, reset 0).
  - spi_miso is sampled on the clk edge where spi_sclk rises, shifted in MSB-first.
  - rd_data is updated with the full 16 bits in the same cycle send_ok_strobe=1, and holds otherwise. An aborted frame leaves rd_data unchanged.
- Undefined: neither port exists; no MISO logic is synthesized.

Test Plan:
- CLK_DIV=2, CS_SETUP=4, CS_HOLD=4, GAP=8; request with dat_spi_in=16'hA5C3:
  - MOSI sampled at the 16 sclk rises = 1010_0101_1100_0011.
  - spi_cs_n low for 4+64+4=72 cycles.
  - Strobe 1+4+64+4+8=81 cycles after accept; exactly one strobe.
- Upstream model clears the request one cycle after the strobe: no second frame starts.
- Request held high for 10 cycles after the strobe: still one frame. Dropping it then starting again gives the second frame, with spi_cs_n high at least 8 cycles between frames.
- rst=1 during bit 7 of SHIFT:
  - Next cycle: spi_cs_n=1, sclk=0, pot_busy=0, no strobe.
  - Request still high after rst=0: full new frame of 16'hA5C3 starting from bit 15.
- dat_spi_in changed from 16'h00FF to 16'hFFFF during SHIFT: transmitted bits remain 16'h00FF.
- POT_SPI_READBACK_EN, MISO model returns 16'h3C5A: rd_data=16'h3C5A in the strobe cycle; previous value before it.
